// File: rtl/branch_pred_pipe_if.sv
// Bundles the fetch/decode/execute branch-prediction signals exchanged between the BTB side and branch_pred_pipe.
// The pipe takes the slave modport, and the BTB/fetch/decoder side takes the master modport.
interface branch_pred_pipe_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
);
  logic            memory_stall;
  logic            flush;
  logic            valid_1;
  logic [PC_W-1:0] instructionPC_1;
  logic            taken_1;
  logic            is_branch_2;
  logic            valid_2;
  logic [PC_W-1:0] instructionPC_2;
  logic            valid_3;
  logic [PC_W-1:0] instructionPC_3;
  logic            is_branchInst_3;
  logic            prev_taken_3;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispredict_cnt;

  modport master (
    output memory_stall, flush, valid_1, instructionPC_1, taken_1, is_branch_2,
    input  valid_2, instructionPC_2, valid_3, instructionPC_3, is_branchInst_3,
           prev_taken_3, branch_cnt, mispredict_cnt
  );

  modport slave (
    input  memory_stall, flush, valid_1, instructionPC_1, taken_1, is_branch_2,
    output valid_2, instructionPC_2, valid_3, instructionPC_3, is_branchInst_3,
           prev_taken_3, branch_cnt, mispredict_cnt
  );
endinterface

// File: rtl/branch_pred_pipe.sv
// Carries fetch-time branch prediction context through decode to execute for BTB update and resolution.
// Define BRANCH_STATS_EN to build the saturating branch_cnt and mispredict_cnt counters. Without it, both counters are tied to 0.
module branch_pred_pipe #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
) (
  input logic              clk,
  input logic              rst,
  branch_pred_pipe_if.slave io_bp
);

  logic            r_v2;
  logic [PC_W-1:0] r_pc2;
  logic            r_pt2;
  logic            r_v3;
  logic [PC_W-1:0] r_pc3;
  logic            r_pt3;
  logic            r_br3;
  logic            w_isBranch3;

  assign w_isBranch3 = r_v3 & r_br3;

  // A stall freezes everything, including a pending flush.
  // A flush only clears the valid bits of the two wrong-path slots.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v2  <= 1'b0;
      r_pc2 <= '0;
      r_pt2 <= 1'b0;
      r_v3  <= 1'b0;
      r_pc3 <= '0;
      r_pt3 <= 1'b0;
      r_br3 <= 1'b0;
    end else if (!io_bp.memory_stall) begin
      r_v2  <= io_bp.valid_1 & ~io_bp.flush;
      r_pc2 <= io_bp.instructionPC_1;
      r_pt2 <= io_bp.taken_1 & io_bp.valid_1;
      r_v3  <= r_v2 & ~io_bp.flush;
      r_pc3 <= r_pc2;
      r_pt3 <= r_pt2;
      r_br3 <= io_bp.is_branch_2 & r_v2;
    end
  end

  assign io_bp.valid_2         = r_v2;
  assign io_bp.instructionPC_2 = r_pc2;
  assign io_bp.valid_3         = r_v3;
  assign io_bp.instructionPC_3 = r_pc3;
  assign io_bp.is_branchInst_3 = w_isBranch3;
  assign io_bp.prev_taken_3    = r_v3 & r_pt3;

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] r_branchCnt;
  logic [CNT_W-1:0] r_mispredictCnt;

  // Counts a branch once, on the unstalled cycle in which it leaves stage 3. Both counters saturate.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_branchCnt     <= '0;
      r_mispredictCnt <= '0;
    end else if (!io_bp.memory_stall && w_isBranch3) begin
      if (r_branchCnt != {CNT_W{1'b1}})
        r_branchCnt <= r_branchCnt + 1'b1;
      if (io_bp.flush && (r_mispredictCnt != {CNT_W{1'b1}}))
        r_mispredictCnt <= r_mispredictCnt + 1'b1;
    end
  end

  assign io_bp.branch_cnt     = r_branchCnt;
  assign io_bp.mispredict_cnt = r_mispredictCnt;
`else
  assign io_bp.branch_cnt     = {CNT_W{1'b0}};
  assign io_bp.mispredict_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_branch_pred_pipe.sv
// Scoreboard bench for branch_pred_pipe.
// Each fetched instruction is queued with its advance stamp and is expected at stage 3 two unstalled edges later.
module tb_branch_pred_pipe;
  localparam int PC_W  = 32;
  localparam int CNT_W = 4;

  typedef struct {
    logic [PC_W-1:0] pc;
    logic            pt;
    logic            br;
    int              stamp;
  } instT;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_pred_pipe_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bpIf ();

  branch_pred_pipe #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .io_bp (bpIf.slave)
  );

  instT sbQ[$];
  instT cur3;
  logic cur3Valid;
  int   advCount;
  int   checks;
  int   errors;
  int   expBranch;
  int   expMisp;

  // Every comparison goes through here.
  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Finds the queued instruction that currently sits in stage 2, if there is one.
  function automatic int stage2Idx();
    for (int i = 0; i < sbQ.size(); i++)
      if (sbQ[i].stamp + 1 == advCount) return i;
    return -1;
  endfunction

  task automatic checkAll();
    int s2;
    s2 = stage2Idx();
    checkOutput("valid_2", 64'(bpIf.valid_2), 64'(s2 >= 0));
    if (s2 >= 0) checkOutput("pc2", 64'(bpIf.instructionPC_2), 64'(sbQ[s2].pc));
    checkOutput("valid_3", 64'(bpIf.valid_3), 64'(cur3Valid));
    if (cur3Valid) checkOutput("pc3", 64'(bpIf.instructionPC_3), 64'(cur3.pc));
    checkOutput("isBranch3", 64'(bpIf.is_branchInst_3), 64'(cur3Valid & cur3.br));
    checkOutput("prevTaken3", 64'(bpIf.prev_taken_3), 64'(cur3Valid & cur3.pt));
    checkOutput("branchCnt", 64'(bpIf.branch_cnt), 64'(expBranch));
    checkOutput("mispredictCnt", 64'(bpIf.mispredict_cnt), 64'(expMisp));
  endtask

  // Drives one cycle of stimulus, predicts the result, steps one clock, then checks.
  task automatic applyStimulus(input logic stall, input logic flush, input logic v1,
                               input logic [PC_W-1:0] pc, input logic tk, input logic br);
    int   s2;
    instT e;
    s2 = stage2Idx();
    bpIf.memory_stall    = stall;
    bpIf.flush           = flush;
    bpIf.valid_1         = v1;
    bpIf.instructionPC_1 = pc;
    bpIf.taken_1         = v1 ? tk : 1'($urandom);
    bpIf.is_branch_2     = (s2 >= 0) ? sbQ[s2].br : 1'($urandom);
`ifdef BRANCH_STATS_EN
    if (!stall && cur3Valid && cur3.br) begin
      if (expBranch < (1 << CNT_W) - 1) expBranch++;
      if (flush && expMisp < (1 << CNT_W) - 1) expMisp++;
    end
`endif
    if (v1 && !stall) begin
      e.pc = pc; e.pt = tk; e.br = br; e.stamp = advCount;
      sbQ.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!stall) begin
      if (flush) sbQ.delete();
      advCount++;
      if (sbQ.size() > 0 && sbQ[0].stamp + 2 == advCount) begin
        cur3      = sbQ.pop_front();
        cur3Valid = 1'b1;
      end else begin
        cur3Valid = 1'b0;
      end
    end
    checkAll();
  endtask

  // Applies reset with the given stall and flush levels held. Everything must read 0 afterwards.
  task automatic applyReset(input logic stall, input logic flush);
    rst                  = 1'b1;
    bpIf.memory_stall    = stall;
    bpIf.flush           = flush;
    bpIf.valid_1         = 1'b1;
    bpIf.instructionPC_1 = 32'hDEAD_BEE0;
    bpIf.taken_1         = 1'b1;
    bpIf.is_branch_2     = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sbQ.delete();
    cur3Valid = 1'b0;
    advCount  = 0;
    expBranch = 0;
    expMisp   = 0;
    checkOutput("rstValid2", 64'(bpIf.valid_2), 64'd0);
    checkOutput("rstPc2", 64'(bpIf.instructionPC_2), 64'd0);
    checkOutput("rstValid3", 64'(bpIf.valid_3), 64'd0);
    checkOutput("rstPc3", 64'(bpIf.instructionPC_3), 64'd0);
    checkOutput("rstBr3", 64'(bpIf.is_branchInst_3), 64'd0);
    checkOutput("rstPt3", 64'(bpIf.prev_taken_3), 64'd0);
    checkOutput("rstBranchCnt", 64'(bpIf.branch_cnt), 64'd0);
    checkOutput("rstMispCnt", 64'(bpIf.mispredict_cnt), 64'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    cur3Valid = 1'b0;
    advCount  = 0;
    expBranch = 0;
    expMisp   = 0;
    cur3.pc = '0; cur3.pt = 1'b0; cur3.br = 1'b0; cur3.stamp = 0;

    applyReset(1'b0, 1'b0);

    // Plain stream of three non-branch instructions.
    applyStimulus(0, 0, 1, 32'h100, 0, 0);
    applyStimulus(0, 0, 1, 32'h104, 0, 0);
    applyStimulus(0, 0, 1, 32'h108, 0, 0);
    applyStimulus(0, 0, 0, 32'h0, 0, 0);
    applyStimulus(0, 0, 0, 32'h0, 0, 0);

    // A predicted-taken branch.
    applyStimulus(0, 0, 1, 32'h200, 1, 1);
    applyStimulus(0, 0, 0, 32'h0, 0, 0);
    checkOutput("br200Pc", 64'(bpIf.instructionPC_3), 64'h200);
    checkOutput("br200Br", 64'(bpIf.is_branchInst_3), 64'd1);
    checkOutput("br200Pt", 64'(bpIf.prev_taken_3), 64'd1);
    applyStimulus(0, 0, 0, 32'h0, 0, 0);

    // A flush while a branch is in stage 3 squashes both younger slots.
    applyReset(1'b0, 1'b0);
    applyStimulus(0, 0, 1, 32'h300, 0, 1);
    applyStimulus(0, 0, 1, 32'h304, 0, 0);
    applyStimulus(0, 1, 1, 32'h308, 0, 0);
    checkOutput("flushValid2", 64'(bpIf.valid_2), 64'd0);
    checkOutput("flushValid3", 64'(bpIf.valid_3), 64'd0);
`ifdef BRANCH_STATS_EN
    checkOutput("flushBranchCnt", 64'(bpIf.branch_cnt), 64'd1);
    checkOutput("flushMispCnt", 64'(bpIf.mispredict_cnt), 64'd1);
`endif
    applyStimulus(0, 0, 1, 32'h30C, 0, 0);

    // A stall holds a pending flush. The squash happens when the stall drops.
    applyReset(1'b0, 1'b0);
    applyStimulus(0, 0, 1, 32'h400, 1, 1);
    applyStimulus(0, 0, 1, 32'h404, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 1, 32'h408, 0, 0);
      checkOutput("stallPc3", 64'(bpIf.instructionPC_3), 64'h400);
      checkOutput("stallBr3", 64'(bpIf.is_branchInst_3), 64'd1);
      checkOutput("stallPc2", 64'(bpIf.instructionPC_2), 64'h404);
      checkOutput("stallBranchCnt", 64'(bpIf.branch_cnt), 64'd0);
    end
    applyStimulus(0, 1, 1, 32'h408, 0, 0);
    checkOutput("unstallValid3", 64'(bpIf.valid_3), 64'd0);
    checkOutput("unstallValid2", 64'(bpIf.valid_2), 64'd0);
    applyStimulus(0, 0, 0, 32'h0, 0, 0);

    // Reset wins while a stall and a flush are both active.
    applyStimulus(0, 0, 1, 32'h500, 1, 1);
    applyStimulus(0, 0, 1, 32'h504, 1, 0);
    applyStimulus(0, 0, 1, 32'h508, 0, 1);
    applyReset(1'b1, 1'b1);

    // Twenty resolved branches saturate the 4-bit branch counter.
    for (int i = 0; i < 20; i++)
      applyStimulus(0, 0, 1, PC_W'(32'h600 + 4 * i), 1'(i), 1);
    applyStimulus(0, 0, 0, 32'h0, 0, 0);
    applyStimulus(0, 0, 0, 32'h0, 0, 0);
`ifdef BRANCH_STATS_EN
    checkOutput("satBranchCnt", 64'(bpIf.branch_cnt), 64'hF);
`else
    checkOutput("noStatsBranchCnt", 64'(bpIf.branch_cnt), 64'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_pred_pipe.md
Name: branch_pred_pipe

Overview:
- Carries each fetched instruction's branch-prediction context from the fetch stage (stage 1) through decode (stage 2) to execute (stage 3).
- Supplies the BTB with stage-3 PC, branch flag and the prediction that was made at fetch (prev_taken_3).
- Freezes on memory stall and squashes wrong-path entries when the BTB raises flush.
- Sits between the BTB's stage-1 prediction outputs and its stage-3 update/resolve inputs.

Parameters:
- PC_W, 32, PC width.
- CNT_W, 32, width of the statistics counters; only used with BRANCH_STATS_EN.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- memory_stall  input  1  global pipeline freeze.
- flush  input  1  BTB mispredict flush (stage-3 resolution).
- valid_1  input  1  stage-1 slot holds a real instruction.
- instructionPC_1  input  PC_W  fetch PC.
- taken_1  input  1  BTB prediction for instructionPC_1.
- is_branch_2  input  1  decode result for the stage-2 instruction, combinational from decoder.
- valid_2  output  1  stage-2 slot valid.
- instructionPC_2  output  PC_W  stage-2 PC, to decoder.
- valid_3  output  1  stage-3 slot valid.
- instructionPC_3  output  PC_W  to BTB.
- is_branchInst_3  output  1  valid_3 & registered branch flag; to BTB.
- prev_taken_3  output  1  prediction made at fetch for the stage-3 instruction; to BTB.
- branch_cnt  output  CNT_W  resolved-branch count.
- mispredict_cnt  output  CNT_W  flush count.

Behaviour:
- State: stage-2 register {v2, pc2, pt2}; stage-3 register {v3, pc3, pt3, br3}.
- Reset: clears all valid bits, PCs, pt and br bits to 0. All outputs read 0 in the cycle after rst is sampled high.
- Reset wins over every other input, including mid-stall and mid-flush.
- Update priority per cycle: rst > memory_stall > flush > advance.
- memory_stall=1: every register holds its value. flush is ignored, and its effect is deferred until the first cycle with stall low. The BTB keeps flush high because its stage-3 inputs are unchanged.
- flush=1 with stall=0:
  - v2 <= 0 and v3 <= 0, because both younger instructions are wrong-path.
  - pc and pt fields may still load. Downstream must qualify with valid.
  - The stage-3 instruction that caused the flush leaves the pipe normally.
- Advance (stall=0, flush=0):
  - {v2, pc2, pt2} <= {valid_1, instructionPC_1, taken_1 & valid_1}.
  - {v3, pc3, pt3} <= {v2, pc2, pt2}.
  - br3 <= is_branch_2 & v2.
- Outputs:
  - is_branchInst_3 = v3 & br3.
  - prev_taken_3 = v3 & pt3.
  - An invalid slot never presents a branch or a prediction.
- Latency: an instruction accepted at stage 1 in cycle N appears at stage 3 in cycle N+2, plus the number of stalled cycles in between.
- Back-to-back flushes: each flush cycle kills both younger slots, so a second flush can only come from a new valid stage-3 branch.

Optional Feature:
BRANCH_STATS_EN
- Defined: two CNT_W counters, reset to 0.
- branch_cnt increments when stall=0 and is_branchInst_3=1.
- mispredict_cnt increments when stall=0, is_branchInst_3=1 and flush=1.
- Both counters saturate at all-ones and never wrap.
- Not defined: no counter registers are built, and branch_cnt and mispredict_cnt are tied to 0.

Test Plan:
- Reset, then stream valid_1=1 with PC 0x100, 0x104, 0x108 and taken_1=0, is_branch_2=0 -> instructionPC_3 = 0x100, 0x104, 0x108 on cycles 2, 3, 4; valid_3=1 and prev_taken_3=0 throughout.
- Fetch 0x200 with taken_1=1, and is_branch_2=1 when it reaches decode -> two cycles later instructionPC_3=0x200, is_branchInst_3=1, prev_taken_3=1.
- Branch at 0x300 is in stage 3, 0x304 and 0x308 are in stages 2/1, and flush=1 for one cycle -> next cycle valid_2=0 and valid_3=0, is_branchInst_3=0, prev_taken_3=0. With stats, mispredict_cnt=1 and branch_cnt=1.
- memory_stall=1 for 3 cycles with flush=1 held and a branch at 0x400 in stage 3 -> all outputs frozen at 0x400 and counters unchanged. The squash occurs on the first cycle after stall drops.
- rst=1 asserted while a stall and a flush are active -> next cycle all valids, PCs and counters are 0.
- BRANCH_STATS_EN with CNT_W=4: 17 resolved branches -> branch_cnt=4'hF (saturated, no wrap).
